irq_ctrl_multi: RTL and testbench

Parametrised interrupt controller for the SoC peripheral subsystem. It aggregates NUM_IRQ interrupt sources into a single CPU interrupt line `intr_o`. Each source is individually selectable as edge- or level-triggered and passes through an optional input synchroniser. The block is configured through an AXI4-lite-subset slave port, with registered read and write responses.

---
 rtl/irq_ctrl_multi.sv | 189 ++++++++++++++++++
 tb/tb_irq_ctrl_multi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_multi.sv
// irq_ctrl_multi: NUM_IRQ-source interrupt controller with an AXI4-lite-subset
// configuration port. Each source has its own synchroniser, edge/level
// pending logic and is merged with enable and master enable into intr_o.

// Per-source lane: optional synchroniser, previous-sample flop, pending bit.
module irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic ack_i,
  output logic pending_o
);
  logic s;
  logic p;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Shift the raw input through SYNC_STAGES flops.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) sync_q <= '0;
        else begin
          sync_q[0] <= irq_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Track the previous synchronised sample for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) p <= 1'b0;
    else        p <= s;
  end

  // Edge mode: a new rising edge beats a same-cycle ack. Level mode: follow s.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)             pending_o <= 1'b0;
    else if (edge_mode_i) begin
      if (s & ~p)           pending_o <= 1'b1;
      else if (ack_i)       pending_o <= 1'b0;
    end else                pending_o <= s;
  end
endmodule

module irq_ctrl_multi #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_awvalid_i,
  output logic                cfg_awready_o,
  input  logic [31:0]         cfg_awaddr_i,
  input  logic                cfg_wvalid_i,
  output logic                cfg_wready_o,
  input  logic [31:0]         cfg_wdata_i,
  input  logic [3:0]          cfg_wstrb_i,
  output logic                cfg_bvalid_o,
  input  logic                cfg_bready_i,
  output logic [1:0]          cfg_bresp_o,
  input  logic                cfg_arvalid_i,
  output logic                cfg_arready_o,
  input  logic [31:0]         cfg_araddr_i,
  output logic                cfg_rvalid_o,
  input  logic                cfg_rready_i,
  output logic [31:0]         cfg_rdata_o,
  output logic [1:0]          cfg_rresp_o,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                intr_o
);
  localparam logic [7:0] A_ISR = 8'h00, A_IPR = 8'h04, A_IER = 8'h08,
                         A_IAR = 8'h0C, A_SIE = 8'h10, A_CIE = 8'h14,
                         A_IVR = 8'h18, A_MER = 8'h1C, A_ITR = 8'h20;

  logic [NUM_IRQ-1:0] pending, ier, itr, ack, ipr;
  logic               me;
  logic               aw_fire, ar_fire;
  logic [7:0]         waddr, raddr;
  logic [NUM_IRQ-1:0] wbits;
  logic [31:0]        ivr, rd_mux;
  logic               unused_bits;

  function automatic logic [31:0] zx(input logic [NUM_IRQ-1:0] v);
    zx = '0;
    zx[NUM_IRQ-1:0] = v;
  endfunction

  assign waddr = cfg_awaddr_i[7:0];
  assign raddr = cfg_araddr_i[7:0];
  assign wbits = cfg_wdata_i[NUM_IRQ-1:0];
  assign unused_bits = ^{cfg_wstrb_i, cfg_awaddr_i[31:8], cfg_araddr_i[31:8], cfg_wdata_i};

  // A pending read blocks the write channel so reads always win.
  assign cfg_arready_o = ~cfg_rvalid_o;
  assign cfg_awready_o = ~cfg_bvalid_o & ~cfg_arvalid_i;
  assign cfg_wready_o  = cfg_awready_o;
  assign cfg_bresp_o   = 2'b00;
  assign cfg_rresp_o   = 2'b00;

  assign aw_fire = cfg_awvalid_i & cfg_wvalid_i & cfg_awready_o;
  assign ar_fire = cfg_arvalid_i & cfg_arready_o;
  assign ack     = (aw_fire && waddr == A_IAR) ? wbits : '0;
  assign ipr     = pending & ier;

  generate
    for (genvar n = 0; n < NUM_IRQ; n++) begin : g_lane
      irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_i       (irq_i[n]),
        .edge_mode_i (itr[n]),
        .ack_i       (ack[n]),
        .pending_o   (pending[n])
      );
    end
  endgenerate

  // Configuration register writes on the write-accept edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ier <= '0;
      itr <= '0;
      me  <= 1'b0;
    end else if (aw_fire) begin
      case (waddr)
        A_IER:   ier <= wbits;
        A_SIE:   ier <= ier | wbits;
        A_CIE:   ier <= ier & ~wbits;
        A_MER:   me  <= cfg_wdata_i[0];
        A_ITR:   itr <= wbits;
        default: ;
      endcase
    end
  end

  // Write response: raised on accept, held until bready.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)            cfg_bvalid_o <= 1'b0;
    else if (aw_fire)      cfg_bvalid_o <= 1'b1;
    else if (cfg_bready_i) cfg_bvalid_o <= 1'b0;
  end

  // Lowest-numbered active source, or all-ones when nothing is active.
  always_comb begin
    ivr = '1;
    for (int n = NUM_IRQ - 1; n >= 0; n--)
      if (ipr[n]) ivr = 32'(n);
  end

  // Read mux over pre-edge register state.
  always_comb begin
    rd_mux = '0;
    case (raddr)
      A_ISR:   rd_mux = zx(pending);
      A_IPR:   rd_mux = zx(ipr);
      A_IER:   rd_mux = zx(ier);
      A_IVR:   rd_mux = ivr;
      A_MER:   rd_mux = {31'b0, me};
      A_ITR:   rd_mux = zx(itr);
      default: rd_mux = '0;
    endcase
  end

  // Read response: data captured on accept, held stable until rready.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
    end else if (ar_fire) begin
      cfg_rvalid_o <= 1'b1;
      cfg_rdata_o  <= rd_mux;
    end else if (cfg_rready_i) begin
      cfg_rvalid_o <= 1'b0;
    end
  end

  // Registered CPU interrupt line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) intr_o <= 1'b0;
    else        intr_o <= me & |ipr;
  end
endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Scoreboard bench for irq_ctrl_multi: a history-based reference model pushes
// expected read/write responses, a negedge monitor pops and compares them.
module tb_irq_ctrl_multi;
  localparam int N  = 8;
  localparam int SS = 2;

  logic clk = 1'b0, rst;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, intr;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [N-1:0] irq;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  irq_ctrl_multi #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_awvalid_i(awvalid), .cfg_awready_o(awready), .cfg_awaddr_i(awaddr),
    .cfg_wvalid_i(wvalid), .cfg_wready_o(wready), .cfg_wdata_i(wdata),
    .cfg_wstrb_i(wstrb), .cfg_bvalid_o(bvalid), .cfg_bready_i(bready),
    .cfg_bresp_o(bresp), .cfg_arvalid_i(arvalid), .cfg_arready_o(arready),
    .cfg_araddr_i(araddr), .cfg_rvalid_o(rvalid), .cfg_rready_i(rready),
    .cfg_rdata_o(rdata), .cfg_rresp_o(rresp), .irq_i(irq), .intr_o(intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_pend, m_ier, m_itr;
  logic         m_me, m_intr, m_rv, m_bv;
  logic [N-1:0] hist[$];        // hist[i]: irq_i sampled i+1 edges ago
  logic [31:0]  rq[$];
  logic [1:0]   bq[$];

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [N-1:0] act;
    act = m_pend & m_ier;
    case (a)
      8'h00: return 32'(m_pend);
      8'h04: return 32'(act);
      8'h08: return 32'(m_ier);
      8'h18: begin
        for (int i = 0; i < N; i++) if (act[i]) return i;
        return 32'hFFFF_FFFF;
      end
      8'h1C: return {31'b0, m_me};
      8'h20: return 32'(m_itr);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = '0; m_ier = '0; m_itr = '0; m_me = 0; m_intr = 0; m_rv = 0; m_bv = 0;
      hist.delete();
      for (int i = 0; i < SS + 2; i++) hist.push_back('0);
      rq.delete(); bq.delete();
    end else begin
      logic [N-1:0] hv[$];
      logic [N-1:0] s, p, ackm, np;
      logic ar_f, aw_f, ni;
      hv = hist; hv.push_front(irq);
      s = hv[SS]; p = hv[SS+1];                  // synchronised now / one edge earlier
      ar_f = arvalid & ~m_rv;
      aw_f = awvalid & wvalid & ~m_bv & ~arvalid;
      if (ar_f) rq.push_back(m_read(araddr[7:0]));
      ni   = m_me & |(m_pend & m_ier);
      ackm = (aw_f && awaddr[7:0] == 8'h0C) ? wdata[N-1:0] : '0;
      for (int n = 0; n < N; n++)
        np[n] = !m_itr[n] ? s[n] : ((s[n] && !p[n]) ? 1'b1 : (m_pend[n] && !ackm[n]));
      if (aw_f) begin
        bq.push_back(2'b00);
        case (awaddr[7:0])
          8'h08: m_ier = wdata[N-1:0];
          8'h10: m_ier = m_ier | wdata[N-1:0];
          8'h14: m_ier = m_ier & ~wdata[N-1:0];
          8'h1C: m_me  = wdata[0];
          8'h20: m_itr = wdata[N-1:0];
          default: ;
        endcase
      end
      if (m_rv && rready) m_rv = 0;
      if (ar_f) m_rv = 1;
      if (m_bv && bready) m_bv = 0;
      if (aw_f) m_bv = 1;
      m_pend = np; m_intr = ni;
      hist.push_front(irq); void'(hist.pop_back());
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("intr_o", {31'b0, intr}, {31'b0, m_intr});
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_unexpected actual=%h required=none", rdata);
        end else chk("rdata", rdata, rq.pop_front());
        chk("rresp", {30'b0, rresp}, 32'h0);
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bvalid_unexpected actual=1 required=0");
        end else chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL %s_timeout actual=stuck required=handshake", name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int t;
    awvalid = 1; wvalid = 1; awaddr = {24'h0, a}; wdata = d; bready = 1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    if (t == 50) timeout("aw");
    step();
    awvalid = 0; wvalid = 0;
    t = 0;
    while (!bvalid && t < 50) begin step(); t++; end
    if (t == 50) timeout("b");
    step();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    int t;
    arvalid = 1; araddr = {24'h0, a}; rready = 1;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    if (t == 50) timeout("ar");
    step();
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin step(); t++; end
    if (t == 50) timeout("r");
    d = rdata;
    step();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  logic [31:0] d;
  logic [7:0]  addrs[10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};

  initial begin
    rst = 0; irq = '0; wstrb = 4'hF;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; wdata = '0; araddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", {31'b0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    rst = 1;
    step();
    chk("awready_idle", {31'b0, awready}, 32'h1);
    chk("arready_idle", {31'b0, arready}, 32'h1);

    // Edge mode: 1-cycle pulse on source 3, check latency edge by edge.
    wr(8'h20, 32'hFF); wr(8'h08, 32'h08); wr(8'h1C, 32'h1);
    irq = 8'h08;
    step();                       // edge 0
    irq = 8'h00;
    chk("lat_e0", {31'b0, intr}, 32'h0);
    step(); chk("lat_e1", {31'b0, intr}, 32'h0);
    step(); chk("lat_e2", {31'b0, intr}, 32'h0);
    step(); chk("lat_e3", {31'b0, intr}, 32'h1);
    rd_chk("edge_isr", 8'h00, 32'h08);
    rd_chk("edge_ivr", 8'h18, 32'h3);
    wr(8'h0C, 32'h08);
    chk("edge_ack_intr", {31'b0, intr}, 32'h0);
    rd_chk("edge_isr_clr", 8'h00, 32'h00);

    // Ack collides with a fresh rising edge on source 0: set wins.
    irq = 8'h01;
    step(); step();               // after edge 1
    awvalid = 1; wvalid = 1; awaddr = 32'h0C; wdata = 32'h01;
    step();                       // edge 2: rise detected and IAR accepted
    awvalid = 0; wvalid = 0;
    step();
    rd_chk("collide_isr", 8'h00, 32'h01);
    wr(8'h0C, 32'h01);            // input still high: no re-set
    repeat (3) step();
    rd_chk("held_isr", 8'h00, 32'h00);
    irq = 8'h00;

    // Level mode.
    wr(8'h20, 32'h0); wr(8'h08, 32'h05); wr(8'h1C, 32'h1);
    irq = 8'h05; repeat (4) step();
    rd_chk("lvl_ivr0", 8'h18, 32'h0);
    wr(8'h0C, 32'h05);
    rd_chk("lvl_isr", 8'h00, 32'h05);
    irq = 8'h04; repeat (4) step();
    rd_chk("lvl_ivr2", 8'h18, 32'h2);
    irq = 8'h00; repeat (4) step();
    rd_chk("lvl_ivr_none", 8'h18, 32'hFFFF_FFFF);
    chk("lvl_intr_low", {31'b0, intr}, 32'h0);

    // Enable set/clear, then master enable off.
    wr(8'h08, 32'h0F); wr(8'h10, 32'h30); wr(8'h14, 32'h03);
    rd_chk("ier_ops", 8'h08, 32'h3C);
    irq = 8'h04; repeat (4) step();
    chk("me_intr_on", {31'b0, intr}, 32'h1);
    wr(8'h1C, 32'h0);
    chk("me_intr_off", {31'b0, intr}, 32'h0);
    irq = 8'h00;

    // Read and write presented together: read first.
    arvalid = 1; araddr = 32'h08; rready = 1;
    awvalid = 1; wvalid = 1; awaddr = 32'h08; wdata = 32'hAA; bready = 1;
    #1 chk("conflict_awready", {31'b0, awready}, 32'h0);
    step();
    arvalid = 0;
    chk("conflict_rdata", rdata, 32'h3C);
    chk("conflict_bvalid0", {31'b0, bvalid}, 32'h0);
    step();
    awvalid = 0; wvalid = 0;
    chk("conflict_bvalid1", {31'b0, bvalid}, 32'h1);
    step();
    rd_chk("conflict_ier", 8'h08, 32'hAA);

    // Read response held with rready low.
    arvalid = 1; araddr = 32'h08; rready = 0;
    step();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {31'b0, rvalid}, 32'h1);
      chk("hold_rdata", rdata, 32'hAA);
      chk("hold_arready", {31'b0, arready}, 32'h0);
      step();
    end
    rready = 1;
    step();
    rd_chk("unmapped", 8'h24, 32'h0);

    // Random traffic against the model.
    for (int it = 0; it < 200; it++) begin
      irq = N'($urandom);
      if ($urandom_range(0, 1) == 0) rd(addrs[$urandom_range(0, 9)], d);
      else wr(addrs[$urandom_range(0, 9)], $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset in the middle of a read.
    irq = '1;
    wr(8'h20, 32'h0); wr(8'h08, 32'hFF); wr(8'h1C, 32'h1);
    repeat (4) step();
    chk("pre_rst_intr", {31'b0, intr}, 32'h1);
    arvalid = 1; araddr = 32'h08; rready = 0;
    step();
    arvalid = 0;
    chk("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
    #2 rst = 0;
    #1;
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_intr", {31'b0, intr}, 32'h0);
    irq = '0;
    step();
    rst = 1; rready = 1;
    step();
    for (int i = 0; i < 10; i++) rd_chk("post_rst_reg", addrs[i], (addrs[i] == 8'h18) ? 32'hFFFF_FFFF : 32'h0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
